// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encodings,
// primary opcodes, ALU operation codes and datapath mux select values.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    I_EXEC    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_RTYPE = 4'd0;
  localparam logic [3:0] ALU_ADD   = 4'd3;
  localparam logic [3:0] ALU_SUB   = 4'd4;
  localparam logic [3:0] ALU_AND   = 4'd5;
  localparam logic [3:0] ALU_OR    = 4'd6;
  localparam logic [3:0] ALU_XOR   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_LUI   = 4'd10;

  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // Every opcode without a legal decode falls back to FETCH, which the
  // controller also uses to flag the instruction as illegal.
  function automatic state_t decode_target(input logic [5:0] opcode);
    state_t target;
    case (opcode)
      OP_RTYPE:                  target = R_EXEC;
      OP_LW, OP_SW:              target = MEM_ADDR;
      OP_BEQ, OP_BNE:            target = BRANCH;
      OP_J:                      target = JUMP;
      OP_ADDI, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI:                    target = I_EXEC;
      default:                   target = FETCH;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// (slave): instruction/status inputs and all datapath control strobes.
interface multicycle_control_if;
  import mips_ctrl_pkg::*;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic       illegal;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, illegal, alu_src_b, pc_src, alu_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, illegal, alu_src_b, pc_src, alu_op, state
  );

endinterface

// File: rtl/imm_aluop_decode.sv
// Maps an I-type primary opcode onto the ALU operation code; non I-type
// opcodes default to ADD.
module imm_aluop_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_ADDI:  alu_op = ALU_ADD;
      OP_SLTI:  alu_op = ALU_SLT;
      OP_SLTIU: alu_op = ALU_SLTU;
      OP_ANDI:  alu_op = ALU_AND;
      OP_ORI:   alu_op = ALU_OR;
      OP_XORI:  alu_op = ALU_XOR;
      OP_LUI:   alu_op = ALU_LUI;
      default:  alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode and the
// per-class execute/memory/write-back steps, with memory wait-state support.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  multicycle_control_if.master bus
);

  state_t     state_q;
  state_t     next_state;
  logic [5:0] op_q;
  logic [3:0] imm_alu_op;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic       illegal;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [3:0] alu_op;

  imm_aluop_decode u_imm_aluop_decode (
    .opcode (op_q),
    .alu_op (imm_alu_op)
  );

  always_comb begin
    next_state = FETCH;
    case (state_q)
      FETCH:     next_state = bus.mem_ready ? DECODE : FETCH;
      DECODE:    next_state = decode_target(bus.opcode);
      MEM_ADDR:  next_state = (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  next_state = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WB:    next_state = FETCH;
      MEM_WRITE: next_state = bus.mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    next_state = R_WB;
      R_WB:      next_state = FETCH;
      I_EXEC:    next_state = I_WB;
      I_WB:      next_state = FETCH;
      BRANCH:    next_state = FETCH;
      JUMP:      next_state = FETCH;
      default:   next_state = FETCH;
    endcase
  end

  // The opcode is captured on leaving DECODE so later states are immune to
  // whatever the instruction register does after that point.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= OP_RTYPE;
    end else begin
      state_q <= next_state;
      if (state_q == DECODE) begin
        op_q <= bus.opcode;
      end
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    illegal    = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    alu_op     = ALU_RTYPE;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
        pc_src    = PC_SRC_ALU;
        ir_write  = bus.mem_ready & ~reset;
        pc_write  = bus.mem_ready & ~reset;
      end
      DECODE: begin
        alu_src_b = SRC_B_IMM_SH2;
        alu_op    = ALU_ADD;
        illegal   = (decode_target(bus.opcode) == FETCH);
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
      end
      MEM_READ: begin
        mem_read = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_RTYPE;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = imm_alu_op;
      end
      I_WB: begin
        reg_write = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = imm_alu_op;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = (op_q == OP_BNE) ? ~bus.zero : bus.zero;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

  assign bus.pc_write   = pc_write;
  assign bus.ir_write   = ir_write;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.illegal    = illegal;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.pc_src     = pc_src;
  assign bus.alu_op     = alu_op;
  assign bus.state      = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all state changes on the rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: opcode  input  6  instruction bits 31:26, sampled from the instruction register.
REQ-004 SHALL have port: zero  input  1  ALU zero flag.
REQ-005 SHALL have port: mem_ready  input  1  memory handshake; access completes in a cycle where mem_ready=1.
REQ-006 SHALL have outputs, all 1-bit: pc_write, ir_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal.
REQ-007 SHALL have output: alu_src_b  output  2  0=regB, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
REQ-008 SHALL have output: pc_src  output  2  0=ALU result, 1=ALUOut (branch target), 2=jump target.
REQ-009 SHALL have output: alu_op  output  4  sent to the ALU operation decoder; 0=R-type (func decode), 3=ADD, 4=SUB, 5=AND, 6=OR, 7=XOR, 8=SLT, 9=SLTU, 10=LUI.
REQ-010 SHALL have output: state  output  4  current FSM state, for debug.

Function
REQ-011 SHALL be a Moore FSM, except for pc_write in BRANCH (REQ-018); outputs not listed for a state SHALL be 0.
REQ-012 SHALL have states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH and JUMP.
REQ-013 FETCH SHALL assert mem_read, alu_src_a=0, alu_src_b=1, alu_op=3 and pc_src=0.
REQ-014 FETCH SHALL hold until mem_ready=1; in that cycle it SHALL also assert ir_write and pc_write, then go to DECODE.
REQ-015 DECODE SHALL drive alu_src_a=0, alu_src_b=3 and alu_op=3 (branch target into ALUOut), then branch on opcode:
- 000000 -> R_EXEC
- 100011 / 101011 -> MEM_ADDR
- 000100 / 000101 -> BRANCH
- 000010 -> JUMP
- 001000, 001010, 001011, 001100, 001101, 001110, 001111 -> I_EXEC
- any other opcode -> FETCH, with illegal=1 for exactly that one cycle
REQ-016 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=2 and alu_op=3, then go to MEM_READ (LW) or MEM_WRITE (SW).
REQ-017 MEM_READ SHALL assert mem_read and hold until mem_ready=1, then go to MEM_WB.
- MEM_WB SHALL assert reg_write and mem_to_reg with reg_dst=0, then go to FETCH.
- MEM_WRITE SHALL assert mem_write and hold until mem_ready=1, then go to FETCH.
REQ-018 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_op=4 and pc_src=1.
- pc_write = zero for BEQ, ~zero for BNE (combinational on zero).
- Next state FETCH.
REQ-019 JUMP SHALL assert pc_write with pc_src=2, then go to FETCH.
REQ-020 R_EXEC SHALL drive alu_src_a=1, alu_src_b=0, alu_op=0, then go to R_WB.
- R_WB SHALL assert reg_write with reg_dst=1, then go to FETCH.
REQ-021 I_EXEC SHALL drive alu_src_a=1, alu_src_b=2, with alu_op by opcode:
- ADDI=3, SLTI=8, SLTIU=9, ANDI=5, ORI=6, XORI=7, LUI=10
- then go to I_WB
REQ-022 I_WB SHALL assert reg_write with reg_dst=0, hold alu_op and alu_src_b from I_EXEC, then go to FETCH.
REQ-023 opcode SHALL be evaluated only in DECODE and later states; changes to opcode during FETCH SHALL have no effect.
REQ-024 The block SHALL never assert mem_read and mem_write in the same cycle, and SHALL never assert ir_write outside FETCH.
REQ-025 Latency without wait states SHALL be:
- LW: 5 cycles
- SW, R-type, I-type: 4 cycles
- BEQ/BNE, J: 3 cycles
- Each mem_ready=0 cycle adds one cycle.

Reset
REQ-026 Asserting reset SHALL force the state to FETCH and all registered outputs to 0 immediately, regardless of clock and including mid-instruction and during a memory wait.
REQ-027 After reset is released, the first rising edge SHALL evaluate FETCH normally. No partial write-back from an aborted instruction SHALL occur.

Structure
REQ-028 State encodings, the opcode constants and the alu_op codes SHALL live in a shared package (mips_ctrl_pkg), also used by the ALU operation decoder.
REQ-029 Opcode-to-alu_op mapping for I-type SHALL be a separate combinational sub-module named imm_aluop_decode.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- LW (opcode 100011), mem_ready=1 always -> FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, FETCH; reg_write=1 only in MEM_WB, mem_to_reg=1.
- FETCH with mem_ready low for 3 cycles -> ir_write and pc_write each high exactly once, in the 4th cycle; state held at FETCH.
- BEQ with zero=1 -> pc_write=1 in BRANCH, pc_src=1. BNE with zero=1 -> pc_write=0.
- ORI (001101) -> alu_op=6 in I_EXEC and I_WB; reg_write=1 only in I_WB, reg_dst=0.
- Opcode 111111 -> illegal pulses for one cycle in DECODE; next state FETCH; no reg_write or mem_write.
- Reset asserted mid-MEM_WRITE, between clock edges -> state=FETCH and mem_write=0 before the next edge; no store completes.
